usb_tx_fsm: RTL and testbench
=============================

# usb_tx_fsm

USB transmit state machine: takes a PID plus an optional byte-stream payload from the protocol layer and serializes a complete USB handshake or DATA packet onto the UTMI transmit interface, generating and appending CRC16 for DATA packets. It is the transmit counterpart of the UTMI receive path: same clock domain, same UTMI byte interface, same PID encoding (low nibble = PID, high nibble = complement). It sits between the device protocol engine and the UTMI PHY wrapper.

## Interface
- `MAX_PAYLOAD`, default 1024: maximum DATA payload bytes; exceeding it aborts the packet.
- `TX_GAP_CYCLES`, default 2: idle cycles enforced after every packet end (done or abort) before a new `tx_start` is accepted; valid range 0-255.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: **synchronous, active-high** reset.
- `tx_start` in 1: request pulse; sampled only in IDLE.
- `tx_pid` in 4: PID to send; sampled with `tx_start`.
- `tx_has_data` in 1: sampled with `tx_start`; 0 with a DATA PID sends a zero-length packet.
- `tx_data` in 8: payload byte.
- `tx_data_valid` in 1: `tx_data` is valid.
- `tx_data_last` in 1: marks the final payload byte.
- `tx_data_ready` out 1: payload byte is consumed this cycle when `tx_data_ready && tx_data_valid`; combinational.
- `utmi_tx_data` out 8: byte to the PHY; registered.
- `utmi_tx_valid` out 1: TxValid; registered; held high for the whole packet.
- `utmi_tx_ready` in 1: TxReady; a byte transfers when `utmi_tx_valid && utmi_tx_ready`.
- `tx_busy` out 1: high from the first PID cycle until the block is back in IDLE, including the gap.
- `tx_done` out 1: one-cycle pulse on a successful packet end.
- `tx_error` out 1: one-cycle pulse on illegal PID, underrun, or overlength.

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP. The state names the byte currently held in the output register.
- IDLE, `tx_start=1`:
  - Legal PIDs are handshakes ACK 0x2, NAK 0xA, STALL 0xE, NYET 0x6, and DATA0/1/2/MDATA 0x3/0xB/0x7/0xF.
  - Legal PID: load `utmi_tx_data={~tx_pid,tx_pid}`, set `utmi_tx_valid=1`, latch `has_data` (forced to 0 for handshakes), CRC register=0xFFFF, byte count=0, go to PID.
  - Illegal PID (token or special): `tx_error` pulse, stay in IDLE, no UTMI activity.
- Byte transfer in any non-IDLE/GAP state loads the next byte into the output register the same cycle, so back-to-back bytes need no bubble:
  - PID, handshake: the transfer ends the packet.
  - PID, ZLP: the transfer loads 0x00 and goes to CRC_LO. The CRC of an empty payload is ~0xFFFF = 0x0000.
  - PID or DATA with payload pending: `tx_data_ready=1` during the transfer.
    - If `tx_data_valid=1`, load `tx_data`, update CRC, and increment count. Go to DATA, or to CRC_LO after loading a byte flagged `tx_data_last` (the CRC_LO byte is loaded on the following transfer).
    - If `tx_data_valid=0`, the payload has underrun: abort.
  - Loading a byte when count already equals `MAX_PAYLOAD`: abort; the byte is not consumed.
  - CRC_LO transfer: load `~crc[15:8]`, go to CRC_HI. The CRC_LO byte itself is `~crc[7:0]`, computed including the last payload byte.
  - CRC_HI transfer: ends the packet.
- CRC16 is the reflected USB form. Process each byte LSB first: `fb=bit^crc[0]; crc=crc>>1; if fb crc^=0xA001`. The reflected CRC run over the payload plus both CRC bytes leaves residue 0xB001.
- `tx_data_ready` is 0 in every other case.
- Packet end: next cycle `utmi_tx_valid=0` and `tx_done=1`, then GAP.
- Abort: next cycle `utmi_tx_valid=0` and `tx_error=1`, then GAP; no `tx_done`.
- GAP: count `TX_GAP_CYCLES` cycles, then IDLE. With `TX_GAP_CYCLES=0`, go to IDLE after 1 cycle. `tx_start` in GAP is ignored (not queued).

## Timing
- Reset values: `utmi_tx_data=0x00`, `utmi_tx_valid=0`, `tx_busy=0`, `tx_done=0`, `tx_error=0`, `tx_data_ready=0`, state IDLE, CRC=0xFFFF, counters 0. Reset mid-packet drops `utmi_tx_valid` on the next edge without an error pulse.
- `tx_start` at edge N puts the PID on `utmi_tx_data` with `utmi_tx_valid=1` and `tx_busy=1` after edge N.
- Handshake with `utmi_tx_ready` constantly high: the PID transfers in cycle N+1, `tx_done` is high in N+2, and the block is back in IDLE after N+2+`TX_GAP_CYCLES`.
- DATA with n payload bytes and no stalls: n+3 bytes are sent in n+3 consecutive cycles.
- `utmi_tx_ready=0` holds `utmi_tx_data` stable; the state and CRC are frozen.
- Simultaneous `tx_data_last` and overlength are resolved as overlength abort.

## Test plan
- ACK (`tx_pid=0x2`) with ready high -> single byte 0xD2; `tx_done` in cycle N+2; `tx_data_ready` never asserted; `tx_busy` drops after the gap.
- DATA0 ZLP (`tx_pid=0x3`, `tx_has_data=0`) -> bytes 0xC3, 0x00, 0x00, then `tx_done`.
- DATA1 payload 0x01..0x04 with random `utmi_tx_ready` stalls -> 0x4B, 01, 02, 03, 04, CRC_LO, CRC_HI; reflected CRC over bytes 2..7 equals 0xB001; no byte duplicated or dropped.
- Underrun: `tx_data_valid` low at the third payload transfer -> `tx_error` pulse, `utmi_tx_valid` low next cycle, no `tx_done`.
- `tx_pid=0x1` (OUT) -> `tx_error` in N+1, `utmi_tx_valid` stays 0. `tx_start` during busy or gap is ignored.
- `MAX_PAYLOAD=4`, 5-byte payload -> 4 bytes sent, abort with `tx_error`, fifth byte not consumed. Separately, `rst` asserted mid-payload -> all outputs at reset values after that edge.

Source files
------------

// File: rtl/usb_tx_fsm.sv
// usb_tx_fsm
// Transmit state machine for the UTMI byte interface. It takes a PID and an
// optional payload stream from the protocol engine and sends a handshake or
// DATA packet to the PHY. For DATA packets it appends the reflected USB CRC16.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   tx_start        : request pulse, sampled only while idle
//   tx_pid          : PID to send, sampled with tx_start
//   tx_has_data     : payload follows (DATA PIDs only; 0 gives a zero-length packet)
//   tx_data         : payload byte
//   tx_data_valid   : tx_data holds a valid byte
//   tx_data_last    : tx_data is the final payload byte
//   tx_data_ready   : payload byte consumed when ready && valid (combinational)
//   utmi_tx_data    : byte presented to the PHY (registered)
//   utmi_tx_valid   : TxValid, held high for the whole packet (registered)
//   utmi_tx_ready   : TxReady; a byte moves when utmi_tx_valid && utmi_tx_ready
//   tx_busy         : high from the PID cycle until idle again, gap included
//   tx_done         : one-cycle pulse after a packet completes
//   tx_error        : one-cycle pulse on illegal PID, underrun or overlength
module usb_tx_fsm #(
  parameter int MAX_PAYLOAD   = 1024,
  parameter int TX_GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_has_data,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_data_last,
  output logic       tx_data_ready,
  output logic [7:0] utmi_tx_data,
  output logic       utmi_tx_valid,
  input  logic       utmi_tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  // A zero-length gap still spends one cycle in GAP.
  localparam int GAP_N = (TX_GAP_CYCLES == 0) ? 1 : TX_GAP_CYCLES;
  localparam logic [7:0]       GAP_LAST = 8'(GAP_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_GAP
  } state_t;

  state_t           state;
  logic             has_data;   // payload requested for this packet
  logic             data_pkt;   // DATA PID (gets CRC), otherwise handshake
  logic             last_held;  // output register holds the final payload byte
  logic [15:0]      crc;
  logic [CNT_W-1:0] count;
  logic [7:0]       gap_cnt;

  logic xfer;
  logic payload_pend;
  logic at_max;

  function automatic logic pid_legal(input logic [3:0] pid);
    case (pid)
      4'h2, 4'hA, 4'hE, 4'h6,
      4'h3, 4'hB, 4'h7, 4'hF: pid_legal = 1'b1;
      default:                pid_legal = 1'b0;
    endcase
  endfunction

  // DATA0/1/2/MDATA all have 11 in the two low PID bits; handshakes have 10.
  function automatic logic pid_is_data(input logic [3:0] pid);
    pid_is_data = (pid[1:0] == 2'b11);
  endfunction

  // Reflected CRC16 (poly 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[0]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    crc16_upd = r;
  endfunction

  always_comb begin
    xfer         = utmi_tx_valid && utmi_tx_ready;
    // The next byte to load comes from the payload stream.
    payload_pend = ((state == S_PID) && has_data) || ((state == S_DATA) && !last_held);
    at_max       = (count == CNT_MAX);
    // Never consume a byte that would overflow the packet.
    tx_data_ready = xfer && payload_pend && !at_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      has_data      <= 1'b0;
      data_pkt      <= 1'b0;
      last_held     <= 1'b0;
      crc           <= 16'hFFFF;
      count         <= '0;
      gap_cnt       <= '0;
      utmi_tx_data  <= 8'h00;
      utmi_tx_valid <= 1'b0;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
      tx_error      <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (state == S_IDLE) begin
        if (tx_start) begin
          if (pid_legal(tx_pid)) begin
            utmi_tx_data  <= {~tx_pid, tx_pid};
            utmi_tx_valid <= 1'b1;
            tx_busy       <= 1'b1;
            data_pkt      <= pid_is_data(tx_pid);
            has_data      <= tx_has_data && pid_is_data(tx_pid);
            last_held     <= 1'b0;
            crc           <= 16'hFFFF;
            count         <= '0;
            state         <= S_PID;
          end else begin
            tx_error <= 1'b1;
          end
        end
      end else if (state == S_GAP) begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end else begin
          gap_cnt <= gap_cnt + 8'd1;
        end
      end else if (xfer) begin
        if (payload_pend) begin
          if (at_max || !tx_data_valid) begin
            // Overlength or underrun: drop TxValid and abort.
            utmi_tx_valid <= 1'b0;
            tx_error      <= 1'b1;
            gap_cnt       <= '0;
            state         <= S_GAP;
          end else begin
            utmi_tx_data <= tx_data;
            crc          <= crc16_upd(crc, tx_data);
            count        <= count + 1'b1;
            last_held    <= tx_data_last;
            state        <= S_DATA;
          end
        end else begin
          case (state)
            S_PID: begin
              if (!data_pkt) begin
                utmi_tx_valid <= 1'b0;
                tx_done       <= 1'b1;
                gap_cnt       <= '0;
                state         <= S_GAP;
              end else begin
                // Zero-length packet: crc is still 0xFFFF, so this loads 0x00.
                utmi_tx_data <= ~crc[7:0];
                state        <= S_CRC_LO;
              end
            end
            S_DATA: begin
              // Only reached with last_held set; crc already covers that byte.
              utmi_tx_data <= ~crc[7:0];
              state        <= S_CRC_LO;
            end
            S_CRC_LO: begin
              utmi_tx_data <= ~crc[15:8];
              state        <= S_CRC_HI;
            end
            S_CRC_HI: begin
              utmi_tx_valid <= 1'b0;
              tx_done       <= 1'b1;
              gap_cnt       <= '0;
              state         <= S_GAP;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_fsm.sv
module tb_usb_tx_fsm;

  localparam int MAXP = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_last;
  logic       tx_data_ready;
  logic [7:0] utmi_tx_data;
  logic       utmi_tx_valid;
  logic       utmi_tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  usb_tx_fsm #(.MAX_PAYLOAD(MAXP), .TX_GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_has_data(tx_has_data), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_last(tx_data_last), .tx_data_ready(tx_data_ready),
    .utmi_tx_data(utmi_tx_data), .utmi_tx_valid(utmi_tx_valid),
    .utmi_tx_ready(utmi_tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pay_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  bit exp_done, exp_err;
  int exp_cons;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: the USB reflected CRC16 over a byte list.
  function automatic logic [15:0] crc_ref(input logic [7:0] q[$], input int from, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int k = from; k < from + n; k++)
      for (int b = 0; b < 8; b++) begin
        bit fb = q[k][b] ^ c[0];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  // Expected packet from the protocol rules.
  function automatic void model(input logic [3:0] pid, input bit has, input int len, input int underrun);
    bit hs  = (pid inside {4'h2, 4'hA, 4'hE, 4'h6});
    bit dat = (pid inside {4'h3, 4'hB, 4'h7, 4'hF});
    bit abort = 0;
    logic [15:0] c;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_cons = 0;
    if (!hs && !dat) begin
      exp_err = 1;
      return;
    end
    exp_q.push_back({~pid, pid});
    if (hs) begin
      exp_done = 1;
      return;
    end
    if (has) begin
      for (int i = 0; i < len; i++) begin
        if (i >= MAXP || i == underrun) begin
          abort = 1;
          break;
        end
        exp_q.push_back(pay_q[i]);
        exp_cons++;
      end
    end
    if (abort) begin
      exp_err = 1;
      return;
    end
    c = has ? crc_ref(pay_q, 0, len) : 16'hFFFF;
    exp_q.push_back(~c[7:0]);
    exp_q.push_back(~c[15:8]);
    exp_done = 1;
  endfunction

  task automatic drive_data(input int idx, input int len, input int underrun);
    if (idx < len) begin
      tx_data       = pay_q[idx];
      tx_data_valid = (idx != underrun);
      tx_data_last  = (idx == len - 1);
    end else begin
      tx_data       = 8'($urandom);
      tx_data_valid = 1'b0;
      tx_data_last  = 1'b0;
    end
  endtask

  task automatic run_packet(input string name, input logic [3:0] pid, input bit has,
                            input int len, input int underrun, input bit stalls, input bit inject);
    int idx = 0, done_n = 0, err_n = 0, consumed = 0, ready_seen = 0;
    int done_cyc = -1, err_cyc = -1, busy_drop = -1, end_cyc;
    bit finished = 0;
    bit is_data = (pid inside {4'h3, 4'hB, 4'h7, 4'hF});
    sent_q.delete();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_pid = pid; tx_has_data = has;
    utmi_tx_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
    drive_data(idx, len, underrun);
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      tx_start    = inject && tx_busy;
      tx_pid      = 4'h2;
      tx_has_data = 1'b0;
      utmi_tx_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_data(idx, len, underrun);
      @(negedge clk);
      if (utmi_tx_valid && utmi_tx_ready) sent_q.push_back(utmi_tx_data);
      if (tx_data_ready) ready_seen++;
      if (tx_data_ready && tx_data_valid) begin consumed++; idx++; end
      if (tx_done)  begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (tx_error) begin err_n++;  if (err_cyc < 0)  err_cyc = cyc;  end
      if (!tx_busy) begin busy_drop = cyc; finished = 1; break; end
    end
    tx_start = 1'b0;
    if (!finished) check({name, " timeout"}, 1, 0);
    model(pid, has, len, underrun);
    check({name, " nbytes"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), sent_q[i], exp_q[i]);
    check({name, " done"}, done_n, exp_done);
    check({name, " error"}, err_n, exp_err);
    check({name, " consumed"}, consumed, exp_cons);
    if (!is_data) check({name, " no ready"}, ready_seen, 0);
    if (exp_done && is_data)
      check({name, " residue"}, crc_ref(sent_q, 1, sent_q.size() - 1), 16'hB001);
    if (exp_q.size() == 0) begin
      check({name, " err cycle"}, err_cyc, 1);
      check({name, " idle cycle"}, busy_drop, 1);
    end else begin
      end_cyc = exp_done ? done_cyc : err_cyc;
      if (!stalls) check({name, " end cycle"}, end_cyc, exp_q.size() + 1);
      check({name, " gap"}, busy_drop, end_cyc + GAP);
    end
  endtask

  task automatic fill(input int len, input bit ramp);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(ramp ? 8'(i + 1) : 8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pid;
    int len;
    rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; tx_has_data = 1'b0;
    tx_data = 8'h00; tx_data_valid = 1'b0; tx_data_last = 1'b0; utmi_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst data", utmi_tx_data, 8'h00);
    check("rst valid", utmi_tx_valid, 0);
    check("rst busy", tx_busy, 0);
    check("rst done", tx_done, 0);
    check("rst error", tx_error, 0);
    check("rst ready", tx_data_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    fill(0, 1); run_packet("ack", 4'h2, 0, 0, 99, 0, 0);
    fill(0, 1); run_packet("zlp", 4'h3, 0, 0, 99, 0, 0);
    fill(4, 1); run_packet("data1 stall", 4'hB, 1, 4, 99, 1, 0);
    fill(4, 1); run_packet("data1", 4'hB, 1, 4, 99, 0, 0);
    fill(4, 0); run_packet("underrun", 4'h3, 1, 4, 2, 0, 0);
    fill(0, 1); run_packet("out pid", 4'h1, 0, 0, 99, 0, 0);
    fill(3, 0); run_packet("start ignored", 4'h7, 1, 3, 99, 1, 1);
    fill(5, 1); run_packet("overlength", 4'hF, 1, 5, 99, 0, 0);
    fill(0, 1); run_packet("stall hs", 4'hE, 1, 0, 99, 1, 1);

    // Reset in the middle of a payload.
    fill(4, 1);
    @(posedge clk); #1;
    tx_start = 1'b1; tx_pid = 4'h3; tx_has_data = 1'b1; utmi_tx_ready = 1'b1;
    drive_data(0, 4, 99);
    @(posedge clk); #1 tx_start = 1'b0;
    drive_data(0, 4, 99);
    @(posedge clk); #1 drive_data(1, 4, 99);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; tx_data_valid = 1'b0;
    @(negedge clk);
    check("midrst data", utmi_tx_data, 8'h00);
    check("midrst valid", utmi_tx_valid, 0);
    check("midrst busy", tx_busy, 0);
    check("midrst done", tx_done, 0);
    check("midrst error", tx_error, 0);
    check("midrst ready", tx_data_ready, 0);
    @(negedge clk);
    check("midrst no error", tx_error, 0);
    check("midrst still idle", utmi_tx_valid, 0);

    for (int t = 0; t < 14; t++) begin
      pid = 4'($urandom);
      if (t % 3 == 0) pid = {pid[3:2], 2'b11};
      len = $urandom_range(1, 6);
      fill(len, 0);
      run_packet($sformatf("rnd%0d", t), pid, 1'($urandom_range(0, 3) != 0), len,
                 $urandom_range(0, 9), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
